// File: rtl/modmul_div_pkg.sv
// Shared widths, state encoding and iteration-count helper for the
// sequential 60/34 restoring divider.
package modmul_div_pkg;

  localparam int DW = 60;  // dividend width
  localparam int BW = 34;  // divisor / remainder width
  localparam int QW = 26;  // quotient width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iterations needed to resolve all QW quotient bits at bpc bits per cycle.
  function automatic int n_iter(int bpc);
    return (bpc == 2) ? QW / 2 : QW;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_restore_step
  import modmul_div_pkg::*;
(
  input  logic [BW-1:0] prem_i,
  input  logic          bit_i,
  input  logic [BW-1:0] b_i,
  output logic [BW-1:0] prem_o,
  output logic          q_o
);

  logic [BW:0] t;

  // prem_i < b_i on entry, so t < 2*b_i and t - b_i always fits in BW bits.
  always_comb begin
    t      = {prem_i, bit_i};
    q_o    = (t >= {1'b0, b_i});
    prem_o = q_o ? BW'(t - {1'b0, b_i}) : t[BW-1:0];
  end

endmodule

// File: rtl/div_60x34_seq.sv
// Sequential restoring divider: C (60b) / B (34b) -> Q (26b), R (34b), err,
// resolving BPC quotient bits per cycle with valid/ready handshakes.
module div_60x34_seq
  import modmul_div_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] C,
  input  logic [BW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] Q,
  output logic [BW-1:0] R,
  output logic          err
);

  localparam int N  = n_iter(BPC);
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  generate
    if (BPC != 1 && BPC != 2) begin : g_bad_bpc
      $error("div_60x34_seq: BPC must be 1 or 2");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [BW-1:0] prem_q, prem_d;
  logic [QW-1:0] qsh_q, qsh_d;
  logic [BW-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  logic [BW-1:0] r_q, r_d;
  logic          err_q, err_d;

  // Combinational chain of BPC restoring steps evaluated each RUN cycle.
  logic [BW-1:0] prem_c [BPC+1];
  logic [QW-1:0] qsh_c  [BPC+1];
  logic          q_bit  [BPC];

  assign prem_c[0] = prem_q;
  assign qsh_c[0]  = qsh_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    div_restore_step u_step (
      .prem_i (prem_c[i]),
      .bit_i  (qsh_c[i][QW-1]),
      .b_i    (b_q),
      .prem_o (prem_c[i+1]),
      .q_o    (q_bit[i])
    );
    assign qsh_c[i+1] = {qsh_c[i][QW-2:0], q_bit[i]};
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    qsh_d   = qsh_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // A high half >= B (including B == 0) would need more than QW quotient bits.
          if (C[DW-1:QW] >= B) begin
            q_d     = '0;
            r_d     = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            prem_d  = C[DW-1:QW];
            qsh_d   = C[QW-1:0];
            b_d     = B;
            cnt_d   = N_CNT;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        prem_d = prem_c[BPC];
        qsh_d  = qsh_c[BPC];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = qsh_c[BPC];
          r_d     = prem_c[BPC];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prem_q  <= '0;
      qsh_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      qsh_q   <= qsh_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign err       = err_q;

endmodule

// File: doc/div_60x34_seq.md
Name: div_60x34_seq

Overview:
Sequential restoring divider that inverts the 26x34 product path. It takes a 60-bit value C and a 34-bit divisor B and returns the 26-bit quotient Q and the 34-bit remainder R, so that C = Q*B + R with R < B. It is used to check and recover operands from DSP multiplier outputs and as a reference reducer in the modmul datapath. Interfaces use valid/ready handshakes, and one operation is in flight at a time.

Parameters:
BPC, 1, quotient bits resolved per cycle; legal values are 1 and 2. Iteration count N = 26/BPC, so N = 26 or 13.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  C/B valid
in_ready  output  1  block can accept an operand
C  input  60  dividend
B  input  34  divisor
out_valid  output  1  Q/R/err valid
out_ready  input  1  consumer accepts the result
Q  output  26  quotient
R  output  34  remainder
err  output  1  overflow or divide-by-zero flag

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state goes to IDLE; in_ready=1; out_valid=0; Q=0; R=0; err=0.
  - Internal remainder, quotient and count registers clear to 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept (IDLE, in_valid=1 at a rising edge):
  - Overflow test: ovf = (C[59:26] >= B). This covers B=0.
  - If ovf: go to DONE with Q=0, R=0, err=1.
  - Else: prem <= C[59:26] (34 bits, guaranteed < B); qsh <= C[25:0]; cnt <= N; go to RUN.
- RUN, each edge, BPC chained restoring steps per cycle. One step:
  - t = {prem, qsh[25]} is 35 bits.
  - If t >= {1'b0, B}: prem <= t - B and the new quotient bit is 1.
  - Else: prem <= t[33:0] and the new quotient bit is 0.
  - qsh shifts left by 1 and the quotient bit enters at bit 0.
- End of RUN:
  - cnt decrements each edge.
  - On the edge where cnt goes 1 to 0, go to DONE; Q <= final qsh, R <= final prem, err <= 0.
- Latency, measured from the accept edge:
  - Normal: out_valid is high after edge N, i.e. 26 cycles at BPC=1 and 13 at BPC=2.
  - Overflow: out_valid is high after 1 edge.
- DONE:
  - Q/R/err are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE; out_valid drops next cycle. Q/R/err keep their last values but are don't-care.
  - Throughput is one result per N+2 cycles minimum.
- Input and output handshakes never coincide, because in_ready=0 in DONE. in_valid during RUN/DONE is ignored; C/B need not be held after acceptance.
- Width rules:
  - The subtract runs on 35 bits; the result always fits in 34 bits because prem < B holds as an invariant.
  - No arithmetic wraps; Q never exceeds 2^26-1 when ovf=0.
- Illegal BPC (not 1 or 2) is rejected at elaboration.

Decomposition:
- Shared package `modmul_div_pkg`:
  - Width constants: DW=60, BW=34, QW=26.
  - State enum IDLE/RUN/DONE.
  - N derivation from BPC.
- One combinational sub-module `div_restore_step`:
  - Inputs: prem, next dividend bit, B.
  - Outputs: new prem, quotient bit.
  - The top instantiates it BPC times in a generate chain.

Test Plan:
- C=60'd12345679, B=34'd1000 -> Q=12345, R=679, err=0. out_valid exactly 26 cycles (BPC=1) or 13 cycles (BPC=2) after the accept edge.
- C=(2^26-1)*(2^34-1), B=34'h3FFFFFFFF -> Q=26'h3FFFFFF, R=0, err=0. Max-width operands.
- Boundary with B=1:
  - C=2^26-1 -> Q=26'h3FFFFFF, R=0, err=0.
  - C=2^26 -> err=1, Q=0, R=0, out_valid 1 cycle after accept.
  - B=0, C=5 -> err=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> Q/R/err stable and in_ready=0 throughout.
  - Raise out_ready -> IDLE next cycle.
  - A back-to-back second op is accepted and returns a correct result.
- Reset mid-RUN: assert rst 10 cycles after accept, asynchronously between edges -> outputs go to 0 immediately, in_ready=1, no spurious out_valid. A new op afterward completes correctly.
- Random regression: 10k random C < B*2^26 plus 5% overflow cases, checked against a model with Q*B+R==C and R<B, for both BPC values.
